// File: rtl/time_set_ctrl.sv
// Digit-editing controller for the MM:SS clock: edge-detects buttons, edits a copy of the
// running time digit by digit, and issues a one-cycle preload strobe on commit.
module time_set_ctrl #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_btn,
  input  logic       right_btn,
  input  logic       left_btn,
  input  logic       inc_btn,
  input  logic       dec_btn,
  input  logic [2:0] cur_min_tens,
  input  logic [3:0] cur_min_ones,
  input  logic [2:0] cur_sec_tens,
  input  logic [3:0] cur_sec_ones,
  output logic [2:0] load_min_tens,
  output logic [3:0] load_min_ones,
  output logic [2:0] load_sec_tens,
  output logic [3:0] load_sec_ones,
  output logic       load_strobe,
  output logic       set_status,
  output logic [3:0] set_id,
  output logic       blink
);
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] BLINK_TC = CW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, EDIT = 2'd1, COMMIT = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [4:0]    btn, btn_prev, ev;
  logic          set_ev, inc_ev, dec_ev, right_ev, left_ev;
  logic [1:0]    cursor;
  logic [CW-1:0] blink_cnt;
  logic [3:0]    sel_digit, sel_max, stepped;

  // Wrapping +/-1 on one BCD digit; out-of-range values snap to 0 (up) or dmax (down).
  function automatic logic [3:0] step_digit(input logic [3:0] d, input logic [3:0] dmax,
                                            input logic up);
    logic [3:0] r;
    if (up) r = (d >= dmax) ? 4'd0 : d + 4'd1;
    else    r = (d == 4'd0 || d > dmax) ? dmax : d - 4'd1;
    return r;
  endfunction

  assign btn      = {set_btn, inc_btn, dec_btn, right_btn, left_btn};
  assign ev       = btn & ~btn_prev;
  assign set_ev   = ev[4];
  assign inc_ev   = ev[3] & ~ev[4];
  assign dec_ev   = ev[2] & ~|ev[4:3];
  assign right_ev = ev[1] & ~|ev[4:2];
  assign left_ev  = ev[0] & ~|ev[4:1];

  // History resets high so a button held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (rst) btn_prev <= '1;
    else     btn_prev <= btn;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (set_ev) state_nxt = EDIT;
      EDIT:    if (set_ev) state_nxt = COMMIT;
      default: state_nxt = IDLE;
    endcase
  end

  // Status stays up through the commit cycle; the strobe is masked by a same-cycle reset.
  always_comb begin
    set_status  = (state != IDLE);
    load_strobe = (state == COMMIT) && !rst;
    set_id      = (state != IDLE) ? (4'b0001 << cursor) : 4'b0000;
  end

  always_comb begin
    case (cursor)
      2'd3:    begin sel_digit = {1'b0, load_min_tens}; sel_max = 4'd5; end
      2'd2:    begin sel_digit = load_min_ones;         sel_max = 4'd9; end
      2'd1:    begin sel_digit = {1'b0, load_sec_tens}; sel_max = 4'd5; end
      default: begin sel_digit = load_sec_ones;         sel_max = 4'd9; end
    endcase
    stepped = step_digit(sel_digit, sel_max, inc_ev);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_min_tens <= '0;
      load_min_ones <= '0;
      load_sec_tens <= '0;
      load_sec_ones <= '0;
      cursor        <= 2'd3;
      blink_cnt     <= '0;
      blink         <= 1'b1;
    end else begin
      blink_cnt <= '0;
      blink     <= 1'b1;
      case (state)
        IDLE: begin
          if (set_ev) begin
            load_min_tens <= cur_min_tens;
            load_min_ones <= cur_min_ones;
            load_sec_tens <= cur_sec_tens;
            load_sec_ones <= cur_sec_ones;
            cursor        <= 2'd3;
          end
        end
        EDIT: begin
          if (blink_cnt == BLINK_TC) begin
            blink_cnt <= '0;
            blink     <= ~blink;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
            blink     <= blink;
          end
          if (set_ev) begin
            blink_cnt <= '0;
            blink     <= 1'b1;
          end else if (inc_ev || dec_ev) begin
            case (cursor)
              2'd3:    load_min_tens <= stepped[2:0];
              2'd2:    load_min_ones <= stepped;
              2'd1:    load_sec_tens <= stepped[2:0];
              default: load_sec_ones <= stepped;
            endcase
          end else if (right_ev || left_ev) begin
            cursor    <= right_ev ? cursor - 2'd1 : cursor + 2'd1;
            blink_cnt <= '0;
            blink     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed button sequences, a per-cycle reference model and
// literal spot checks on the edited digits, cursor, strobe and blink pattern.
module tb_time_set_ctrl;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btns = '1;   // [4]=set [3]=inc [2]=dec [1]=right [0]=left
  logic [2:0] cur_min_tens = 3'd1;
  logic [3:0] cur_min_ones = 4'd2;
  logic [2:0] cur_sec_tens = 3'd3;
  logic [3:0] cur_sec_ones = 4'd4;
  logic [2:0] load_min_tens, load_sec_tens;
  logic [3:0] load_min_ones, load_sec_ones;
  logic       load_strobe, set_status, blink;
  logic [3:0] set_id;

  always #5 clk = ~clk;

  time_set_ctrl #(.BLINK_DIV(DIV)) dut (
    .clk(clk), .rst(rst),
    .set_btn(btns[4]), .right_btn(btns[1]), .left_btn(btns[0]),
    .inc_btn(btns[3]), .dec_btn(btns[2]),
    .cur_min_tens(cur_min_tens), .cur_min_ones(cur_min_ones),
    .cur_sec_tens(cur_sec_tens), .cur_sec_ones(cur_sec_ones),
    .load_min_tens(load_min_tens), .load_min_ones(load_min_ones),
    .load_sec_tens(load_sec_tens), .load_sec_ones(load_sec_ones),
    .load_strobe(load_strobe), .set_status(set_status), .set_id(set_id), .blink(blink)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=idle 1=edit 2=commit; m_d[3..0] = MT,MO,ST,SO; m_age = cycles since blink restart.
  int         m_mode = 0;
  int         m_d[4] = '{0, 0, 0, 0};
  int         m_cur  = 3;
  int         m_age  = 0;
  logic [4:0] m_prev = '1;

  function automatic int digit_max(input int i);
    return (i % 2 == 1) ? 5 : 9;
  endfunction

  function automatic int cur_digit(input int i);
    case (i)
      3:       return int'(cur_min_tens);
      2:       return int'(cur_min_ones);
      1:       return int'(cur_sec_tens);
      default: return int'(cur_sec_ones);
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [4:0] e;
    int mx;
    if (rst) begin
      m_mode = 0; m_cur = 3; m_age = 0; m_prev = '1;
      for (int i = 0; i < 4; i++) m_d[i] = 0;
    end else begin
      e = btns & ~m_prev;
      m_prev = btns;
      case (m_mode)
        0: if (e[4]) begin
             for (int i = 0; i < 4; i++) m_d[i] = cur_digit(i);
             m_cur = 3; m_age = 0; m_mode = 1;
           end
        1: begin
             m_age++;
             mx = digit_max(m_cur);
             if (e[4]) m_mode = 2;
             else if (e[3]) m_d[m_cur] = (m_d[m_cur] > mx) ? 0 : (m_d[m_cur] + 1) % (mx + 1);
             else if (e[2]) m_d[m_cur] = (m_d[m_cur] > mx) ? mx : (m_d[m_cur] + mx) % (mx + 1);
             else if (e[1]) begin m_cur = (m_cur + 3) % 4; m_age = 0; end
             else if (e[0]) begin m_cur = (m_cur + 1) % 4; m_age = 0; end
           end
        default: m_mode = 0;
      endcase
    end
  end

  function automatic logic [15:0] load_vec();
    return {1'b0, load_min_tens, load_min_ones, 1'b0, load_sec_tens, load_sec_ones};
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_set_status", set_status, m_mode != 0);
      chk("model_load_strobe", load_strobe, m_mode == 2 && !rst);
      chk("model_set_id", set_id, (m_mode != 0) ? (1 << m_cur) : 0);
      chk("model_blink", blink, (m_mode == 1) ? ((m_age / DIV) % 2 == 0) : 1);
      chk("model_load", load_vec(), m_d[3] * 4096 + m_d[2] * 256 + m_d[1] * 16 + m_d[0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int b);
    btns[b] = 1'b1;
    tick();
    btns[b] = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int         exp_mt[5] = '{2, 3, 4, 5, 0};
    logic [3:0] exp_id[4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    logic [11:0] pat12;
    logic [7:0]  pat8;

    // 1: reset with buttons held, then release
    repeat (3) tick();
    cmp_en = 1'b1;
    rst = 1'b0;
    repeat (2) tick();
    btns = '0;
    repeat (2) tick();
    @(negedge clk);
    chk("t1_status", set_status, 0);
    chk("t1_set_id", set_id, 0);
    chk("t1_blink", blink, 1);
    chk("t1_load", load_vec(), 16'h0000);

    // 2: enter edit at 12:34, bump minutes tens five times, commit
    press(4);
    @(negedge clk);
    chk("t2_load_copy", load_vec(), 16'h1234);
    chk("t2_set_id", set_id, 4'b1000);
    for (int i = 0; i < 5; i++) begin
      press(3);
      @(negedge clk);
      chk("t2_min_tens", load_min_tens, exp_mt[i]);
    end
    btns[4] = 1'b1;
    tick();
    @(negedge clk);
    chk("t2_strobe", load_strobe, 1);
    chk("t2_commit_load", load_vec(), 16'h0234);
    btns[4] = 1'b0;
    tick();
    @(negedge clk);
    chk("t2_strobe_end", load_strobe, 0);
    chk("t2_status_end", set_status, 0);

    // 3: cursor moves and a decrement that wraps 0 -> 9
    cur_sec_ones = 4'd0;
    press(4);
    @(negedge clk);
    chk("t3_load_copy", load_vec(), 16'h1230);
    for (int i = 0; i < 4; i++) begin
      press(1);
      @(negedge clk);
      chk("t3_right_id", set_id, exp_id[i]);
    end
    press(0);
    @(negedge clk);
    chk("t3_left_id", set_id, 4'b0001);
    press(2);
    @(negedge clk);
    chk("t3_dec_wrap", load_vec(), 16'h1239);

    // 4: inc beats dec; set beats inc
    btns[3] = 1'b1; btns[2] = 1'b1;
    tick();
    btns = '0;
    tick();
    @(negedge clk);
    chk("t4_inc_over_dec", load_vec(), 16'h1230);
    btns[4] = 1'b1; btns[3] = 1'b1;
    tick();
    @(negedge clk);
    chk("t4_set_strobe", load_strobe, 1);
    chk("t4_set_load", load_vec(), 16'h1230);
    btns = '0;
    tick();
    @(negedge clk);
    chk("t4_idle", set_status, 0);

    // 5: blink cadence, restart on cursor move, steady after commit
    btns[4] = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pat12[11 - i] = blink;
      btns[4] = 1'b0;
    end
    chk("t5_blink_run", pat12, 12'b1111_0000_1111);
    btns[1] = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pat8[7 - i] = blink;
      btns[1] = 1'b0;
    end
    chk("t5_blink_restart", pat8, 8'b1111_0000);
    btns[4] = 1'b1;
    tick();
    btns[4] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pat8[7 - i] = blink;
    end
    chk("t5_blink_idle", pat8, 8'hFF);

    // 6: reset during the commit cycle drops the strobe
    press(4);
    btns[4] = 1'b1;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_no_strobe", load_strobe, 0);
    btns = '0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_status", set_status, 0);
    chk("t6_set_id", set_id, 0);
    chk("t6_blink", blink, 1);
    chk("t6_load", load_vec(), 16'h0000);
    repeat (3) tick();

    @(negedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
